// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode encodings, ALU codes, T-state constants and the control-word layout.
// CU_MULDIV_EN selects whether mul/div get their own execute sequence or decode as nop.
package cpu_pkg;

   localparam logic [4:0] OP_LD   = 5'd0;
   localparam logic [4:0] OP_LDI  = 5'd1;
   localparam logic [4:0] OP_ST   = 5'd2;
   localparam logic [4:0] OP_ADD  = 5'd3;
   localparam logic [4:0] OP_SUB  = 5'd4;
   localparam logic [4:0] OP_SHR  = 5'd5;
   localparam logic [4:0] OP_SHL  = 5'd6;
   localparam logic [4:0] OP_ROR  = 5'd7;
   localparam logic [4:0] OP_ROL  = 5'd8;
   localparam logic [4:0] OP_AND  = 5'd9;
   localparam logic [4:0] OP_OR   = 5'd10;
   localparam logic [4:0] OP_ADDI = 5'd11;
   localparam logic [4:0] OP_ANDI = 5'd12;
   localparam logic [4:0] OP_ORI  = 5'd13;
   localparam logic [4:0] OP_MUL  = 5'd14;
   localparam logic [4:0] OP_DIV  = 5'd15;
   localparam logic [4:0] OP_BR   = 5'd18;
   localparam logic [4:0] OP_JR   = 5'd19;
   localparam logic [4:0] OP_JAL  = 5'd20;
   localparam logic [4:0] OP_IN   = 5'd21;
   localparam logic [4:0] OP_OUT  = 5'd22;
   localparam logic [4:0] OP_MFHI = 5'd23;
   localparam logic [4:0] OP_MFLO = 5'd24;
   localparam logic [4:0] OP_NOP  = 5'd25;
   localparam logic [4:0] OP_HALT = 5'd26;

   // ALU codes share the opcode numbering, so ALU ops pass the opcode straight through
   localparam logic [4:0] ALU_ADD = OP_ADD;

   localparam logic [2:0] T0 = 3'd0;
   localparam logic [2:0] T1 = 3'd1;
   localparam logic [2:0] T2 = 3'd2;
   localparam logic [2:0] T3 = 3'd3;
   localparam logic [2:0] T4 = 3'd4;
   localparam logic [2:0] T5 = 3'd5;
   localparam logic [2:0] T6 = 3'd6;
   localparam logic [2:0] T7 = 3'd7;

   typedef enum logic [1:0] {
      MODE_IDLE,
      MODE_RUN,
      MODE_HALT
   } mode_t;

   typedef struct packed {
      logic       pc_out;
      logic       mdr_out;
      logic       zhigh_out;
      logic       zlow_out;
      logic       hi_out;
      logic       lo_out;
      logic       inport_out;
      logic       c_out;
      logic       pc_in;
      logic       ir_in;
      logic       mar_in;
      logic       mdr_in;
      logic       y_in;
      logic       zhigh_in;
      logic       zlow_in;
      logic       hi_in;
      logic       lo_in;
      logic       outport_in;
      logic       con_in;
      logic       inc_pc;
      logic       gra;
      logic       grb;
      logic       grc;
      logic       r_in;
      logic       r_out;
      logic       ba_out;
      logic       read;
      logic       write;
      logic [4:0] alu_op;
   } ctl_t;

   // Final T-state of each instruction; nop, halt and undefined opcodes end with fetch.
   function automatic logic [2:0] last_step(input logic [4:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_SHR, OP_SHL, OP_ROR, OP_ROL,
         OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:       last_step = T5;
         OP_LD:                                  last_step = T7;
         OP_ST, OP_BR:                           last_step = T6;
         OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: last_step = T3;
         OP_JAL:                                 last_step = T4;
`ifdef CU_MULDIV_EN
         OP_MUL, OP_DIV:                         last_step = T6;
`else
         OP_MUL, OP_DIV:                         last_step = T2;
`endif
         default:                                last_step = T2;
      endcase
   endfunction

endpackage

// File: rtl/cu_step_counter.sv
// cu_step_counter: 3-bit T-state counter with synchronous zero (priority) and hold.
// Latency: count changes on the rising edge after zero/hold are sampled.
// Backpressure: none; hold freezes the count.
module cu_step_counter (
   input  logic       clock,
   input  logic       clear,
   input  logic       zero,
   input  logic       hold,
   output logic [2:0] count
);

   always_ff @(posedge clock or negedge clear) begin
      if (!clear)
         count <= 3'd0;
      else if (zero)
         count <= 3'd0;
      else if (!hold)
         count <= count + 3'd1;
   end

endmodule

// File: rtl/control_unit.sv
// control_unit: Moore control FSM; controls decoded from (mode, step) plus ir/con. CU_MULDIV_EN adds mul/div.
// Latency: one T-state per clock, first fetch T0 on the first edge after clear rises.
// Backpressure: stop is honoured only at an instruction's final T-state; halt holds until clear.
module control_unit
   import cpu_pkg::*;
(
   input  logic        clock,
   input  logic        clear,
   input  logic        stop,
   input  logic [31:0] ir,
   input  logic        con,
   output logic        PCout,
   output logic        MDRout,
   output logic        Zhighout,
   output logic        Zlowout,
   output logic        HIout,
   output logic        LOout,
   output logic        InPortout,
   output logic        Cout,
   output logic        PCin,
   output logic        IRin,
   output logic        MARin,
   output logic        MDRin,
   output logic        Yin,
   output logic        Zhighin,
   output logic        Zlowin,
   output logic        HIin,
   output logic        LOin,
   output logic        OutPortin,
   output logic        CONin,
   output logic        IncPC,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        Read,
   output logic        Write,
   output logic [4:0]  alu_op,
   output logic        run,
   output logic [2:0]  step
);

   mode_t      mode;
   ctl_t       ctl;
   logic [4:0] opcode;
   logic       at_end;
   logic       unused_ir;

   assign opcode    = ir[31:27];
   assign unused_ir = ^ir[26:0];
   // The decoder trusts ir from T2 onward, when the incoming instruction is on it.
   assign at_end    = (mode == MODE_RUN) && (step == last_step(opcode));

   cu_step_counter u_step (
      .clock (clock),
      .clear (clear),
      .zero  (at_end || (mode == MODE_IDLE)),
      .hold  (mode == MODE_HALT),
      .count (step)
   );

   // IDLE spends the first post-reset edge so all controls stay low while clear is asserted.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         mode <= MODE_IDLE;
      end else begin
         case (mode)
            MODE_IDLE: mode <= MODE_RUN;
            MODE_RUN:  if (at_end && (stop || (opcode == OP_HALT))) mode <= MODE_HALT;
            default:   mode <= MODE_HALT;
         endcase
      end
   end

   always_comb begin
      ctl = '0;
      if (mode == MODE_RUN) begin
         case (step)
            T0: begin ctl.pc_out = 1'b1; ctl.mar_in = 1'b1; ctl.inc_pc = 1'b1; ctl.zlow_in = 1'b1; end
            T1: begin ctl.zlow_out = 1'b1; ctl.pc_in = 1'b1; ctl.read = 1'b1; ctl.mdr_in = 1'b1; end
            T2: begin ctl.mdr_out = 1'b1; ctl.ir_in = 1'b1; end
            default: begin
               case (opcode)
                  OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
                  OP_ADDI, OP_ANDI, OP_ORI: begin
                     case (step)
                        T3: begin ctl.grb = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1; end
                        T4: begin
                           if (opcode == OP_ADDI || opcode == OP_ANDI || opcode == OP_ORI)
                              ctl.c_out = 1'b1;
                           else begin
                              ctl.grc   = 1'b1;
                              ctl.r_out = 1'b1;
                           end
                           ctl.alu_op  = opcode;
                           ctl.zlow_in = 1'b1;
                        end
                        T5: begin ctl.zlow_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                        default: ;
                     endcase
                  end
                  OP_LD, OP_LDI, OP_ST: begin
                     case (step)
                        T3: begin ctl.grb = 1'b1; ctl.ba_out = 1'b1; ctl.y_in = 1'b1; end
                        T4: begin ctl.c_out = 1'b1; ctl.alu_op = ALU_ADD; ctl.zlow_in = 1'b1; end
                        T5: begin
                           ctl.zlow_out = 1'b1;
                           if (opcode == OP_LDI) begin
                              ctl.gra  = 1'b1;
                              ctl.r_in = 1'b1;
                           end else
                              ctl.mar_in = 1'b1;
                        end
                        T6: begin
                           if (opcode == OP_LD) begin
                              ctl.read   = 1'b1;
                              ctl.mdr_in = 1'b1;
                           end else if (opcode == OP_ST) begin
                              ctl.gra   = 1'b1;
                              ctl.r_out = 1'b1;
                              ctl.write = 1'b1;
                           end
                        end
                        T7: if (opcode == OP_LD) begin
                           ctl.mdr_out = 1'b1;
                           ctl.gra     = 1'b1;
                           ctl.r_in    = 1'b1;
                        end
                        default: ;
                     endcase
                  end
                  OP_BR: begin
                     case (step)
                        T3: begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.con_in = 1'b1; end
                        T4: begin ctl.pc_out = 1'b1; ctl.y_in = 1'b1; end
                        T5: begin ctl.c_out = 1'b1; ctl.alu_op = ALU_ADD; ctl.zlow_in = 1'b1; end
                        T6: begin ctl.zlow_out = con; ctl.pc_in = con; end
                        default: ;
                     endcase
                  end
                  OP_JR: if (step == T3) begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.pc_in = 1'b1; end
                  OP_JAL: begin
                     // Link address goes to r15 through the Grb path.
                     if (step == T3) begin ctl.pc_out = 1'b1; ctl.grb = 1'b1; ctl.r_in = 1'b1; end
                     if (step == T4) begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.pc_in = 1'b1; end
                  end
                  OP_IN:   if (step == T3) begin ctl.inport_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                  OP_OUT:  if (step == T3) begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.outport_in = 1'b1; end
                  OP_MFHI: if (step == T3) begin ctl.hi_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
                  OP_MFLO: if (step == T3) begin ctl.lo_out = 1'b1; ctl.gra = 1'b1; ctl.r_in = 1'b1; end
`ifdef CU_MULDIV_EN
                  OP_MUL, OP_DIV: begin
                     case (step)
                        T3: begin ctl.gra = 1'b1; ctl.r_out = 1'b1; ctl.y_in = 1'b1; end
                        T4: begin
                           ctl.grb      = 1'b1;
                           ctl.r_out    = 1'b1;
                           ctl.alu_op   = opcode;
                           ctl.zlow_in  = 1'b1;
                           ctl.zhigh_in = 1'b1;
                        end
                        T5: begin ctl.zlow_out = 1'b1; ctl.lo_in = 1'b1; end
                        T6: begin ctl.zhigh_out = 1'b1; ctl.hi_in = 1'b1; end
                        default: ;
                     endcase
                  end
`endif
                  default: ;
               endcase
            end
         endcase
      end
   end

   assign run       = (mode != MODE_HALT);
   assign PCout     = ctl.pc_out;
   assign MDRout    = ctl.mdr_out;
   assign Zhighout  = ctl.zhigh_out;
   assign Zlowout   = ctl.zlow_out;
   assign HIout     = ctl.hi_out;
   assign LOout     = ctl.lo_out;
   assign InPortout = ctl.inport_out;
   assign Cout      = ctl.c_out;
   assign PCin      = ctl.pc_in;
   assign IRin      = ctl.ir_in;
   assign MARin     = ctl.mar_in;
   assign MDRin     = ctl.mdr_in;
   assign Yin       = ctl.y_in;
   assign Zhighin   = ctl.zhigh_in;
   assign Zlowin    = ctl.zlow_in;
   assign HIin      = ctl.hi_in;
   assign LOin      = ctl.lo_in;
   assign OutPortin = ctl.outport_in;
   assign CONin     = ctl.con_in;
   assign IncPC     = ctl.inc_pc;
   assign Gra       = ctl.gra;
   assign Grb       = ctl.grb;
   assign Grc       = ctl.grc;
   assign Rin       = ctl.r_in;
   assign Rout      = ctl.r_out;
   assign BAout     = ctl.ba_out;
   assign Read      = ctl.read;
   assign Write     = ctl.write;
   assign alu_op    = ctl.alu_op;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: drives instruction sequences into control_unit and checks every T-state
// against a per-instruction microprogram (queue of expected control words) built in the bench.
module tb_control_unit;
   import cpu_pkg::*;

   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic        stop  = 1'b0;
   logic [31:0] ir    = 32'd0;
   logic        con   = 1'b0;
   logic PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout, Cout;
   logic PCin, IRin, MARin, MDRin, Yin, Zhighin, Zlowin, HIin, LOin, OutPortin, CONin, IncPC;
   logic Gra, Grb, Grc, Rin, Rout, BAout, Read, Write;
   logic [4:0] alu_op;
   logic       run;
   logic [2:0] step;

   int n_checks = 0;
   int n_fail   = 0;

   control_unit dut (
      .clock(clock), .clear(clear), .stop(stop), .ir(ir), .con(con),
      .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
      .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
      .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
      .Zhighin(Zhighin), .Zlowin(Zlowin), .HIin(HIin), .LOin(LOin),
      .OutPortin(OutPortin), .CONin(CONin), .IncPC(IncPC),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .Read(Read), .Write(Write), .alu_op(alu_op), .run(run), .step(step)
   );

   always #5 clock = ~clock;

   // Observed control word; bits [7:0] are the bus drivers.
   logic [32:0] obs;
   assign obs = {alu_op, Write, Read, BAout, Rout, Rin, Grc, Grb, Gra, IncPC, CONin, OutPortin,
                 LOin, HIin, Zlowin, Zhighin, Yin, MDRin, MARin, IRin, PCin, Cout, InPortout,
                 LOout, HIout, Zlowout, Zhighout, MDRout, PCout};

   localparam logic [32:0] S_PCOUT  = 33'd1 << 0,  S_MDROUT  = 33'd1 << 1,  S_ZHIOUT = 33'd1 << 2;
   localparam logic [32:0] S_ZLOOUT = 33'd1 << 3,  S_HIOUT   = 33'd1 << 4,  S_LOOUT  = 33'd1 << 5;
   localparam logic [32:0] S_INPOUT = 33'd1 << 6,  S_COUT    = 33'd1 << 7,  S_PCIN   = 33'd1 << 8;
   localparam logic [32:0] S_IRIN   = 33'd1 << 9,  S_MARIN   = 33'd1 << 10, S_MDRIN  = 33'd1 << 11;
   localparam logic [32:0] S_YIN    = 33'd1 << 12, S_ZHIIN   = 33'd1 << 13, S_ZLOIN  = 33'd1 << 14;
   localparam logic [32:0] S_HIIN   = 33'd1 << 15, S_LOIN    = 33'd1 << 16, S_OUTPIN = 33'd1 << 17;
   localparam logic [32:0] S_CONIN  = 33'd1 << 18, S_INCPC   = 33'd1 << 19, S_GRA    = 33'd1 << 20;
   localparam logic [32:0] S_GRB    = 33'd1 << 21, S_GRC     = 33'd1 << 22, S_RIN    = 33'd1 << 23;
   localparam logic [32:0] S_ROUT   = 33'd1 << 24, S_BAOUT   = 33'd1 << 25, S_READ   = 33'd1 << 26;
   localparam logic [32:0] S_WRITE  = 33'd1 << 27;

   logic [32:0] prog[$];

   function automatic logic [32:0] alu(input logic [4:0] v);
      alu = {v, 28'd0};
   endfunction

   // Microprogram of one whole instruction, one entry per T-state.
   function automatic void build_prog(input logic [4:0] op, input logic c);
      prog.delete();
      prog.push_back(S_PCOUT | S_MARIN | S_INCPC | S_ZLOIN);
      prog.push_back(S_ZLOOUT | S_PCIN | S_READ | S_MDRIN);
      prog.push_back(S_MDROUT | S_IRIN);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL: begin
            prog.push_back(S_GRB | S_ROUT | S_YIN);
            prog.push_back(S_GRC | S_ROUT | S_ZLOIN | alu(op));
            prog.push_back(S_ZLOOUT | S_GRA | S_RIN);
         end
         OP_ADDI, OP_ANDI, OP_ORI: begin
            prog.push_back(S_GRB | S_ROUT | S_YIN);
            prog.push_back(S_COUT | S_ZLOIN | alu(op));
            prog.push_back(S_ZLOOUT | S_GRA | S_RIN);
         end
         OP_LDI: begin
            prog.push_back(S_GRB | S_BAOUT | S_YIN);
            prog.push_back(S_COUT | S_ZLOIN | alu(ALU_ADD));
            prog.push_back(S_ZLOOUT | S_GRA | S_RIN);
         end
         OP_LD: begin
            prog.push_back(S_GRB | S_BAOUT | S_YIN);
            prog.push_back(S_COUT | S_ZLOIN | alu(ALU_ADD));
            prog.push_back(S_ZLOOUT | S_MARIN);
            prog.push_back(S_READ | S_MDRIN);
            prog.push_back(S_MDROUT | S_GRA | S_RIN);
         end
         OP_ST: begin
            prog.push_back(S_GRB | S_BAOUT | S_YIN);
            prog.push_back(S_COUT | S_ZLOIN | alu(ALU_ADD));
            prog.push_back(S_ZLOOUT | S_MARIN);
            prog.push_back(S_GRA | S_ROUT | S_WRITE);
         end
         OP_BR: begin
            prog.push_back(S_GRA | S_ROUT | S_CONIN);
            prog.push_back(S_PCOUT | S_YIN);
            prog.push_back(S_COUT | S_ZLOIN | alu(ALU_ADD));
            prog.push_back(c ? (S_ZLOOUT | S_PCIN) : 33'd0);
         end
         OP_JR:   prog.push_back(S_GRA | S_ROUT | S_PCIN);
         OP_JAL: begin
            prog.push_back(S_PCOUT | S_GRB | S_RIN);
            prog.push_back(S_GRA | S_ROUT | S_PCIN);
         end
         OP_IN:   prog.push_back(S_INPOUT | S_GRA | S_RIN);
         OP_OUT:  prog.push_back(S_GRA | S_ROUT | S_OUTPIN);
         OP_MFHI: prog.push_back(S_HIOUT | S_GRA | S_RIN);
         OP_MFLO: prog.push_back(S_LOOUT | S_GRA | S_RIN);
`ifdef CU_MULDIV_EN
         OP_MUL, OP_DIV: begin
            prog.push_back(S_GRA | S_ROUT | S_YIN);
            prog.push_back(S_GRB | S_ROUT | S_ZLOIN | S_ZHIIN | alu(op));
            prog.push_back(S_ZLOOUT | S_LOIN);
            prog.push_back(S_ZHIOUT | S_HIIN);
         end
`endif
         default: ;
      endcase
   endfunction

   // Entered just after a rising edge with the DUT at T0; leaves just after the edge that ends
   // the instruction (or right after sampling step abort_at).
   task automatic run_instr(input logic [31:0] instr, input logic c, input logic stop_req,
                            input int abort_at, output logic halted);
      ir  = instr;
      con = c;
      build_prog(instr[31:27], c);
      halted = 1'b0;
      for (int i = 0; i < prog.size(); i++) begin
         stop = stop_req && (i == prog.size() - 1);
         @(negedge clock);
         n_checks++;
         if (step !== i[2:0]) begin
            n_fail++;
            $display("FAIL step op=%0d: got %0d want %0d", instr[31:27], step, i);
         end
         n_checks++;
         if (obs !== prog[i]) begin
            n_fail++;
            $display("FAIL ctrl op=%0d T%0d con=%b: got %h want %h", instr[31:27], i, c, obs, prog[i]);
         end
         n_checks++;
         if (run !== 1'b1) begin
            n_fail++;
            $display("FAIL run op=%0d T%0d: got %b want 1", instr[31:27], i, run);
         end
         n_checks++;
         if ((Read && Write) || ($countones(obs[7:0]) > 1)) begin
            n_fail++;
            $display("FAIL exclusive op=%0d T%0d: got rd=%b wr=%b drv=%b want rd&wr=0, <=1 driver",
                     instr[31:27], i, Read, Write, obs[7:0]);
         end
         if (i == abort_at) return;
         @(posedge clock); #1;
      end
      stop   = 1'b0;
      halted = stop_req || (instr[31:27] == OP_HALT);
   endtask

   task automatic check_halted(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         n_checks++;
         if (run !== 1'b0 || obs !== 33'd0) begin
            n_fail++;
            $display("FAIL halted cyc%0d: got run=%b ctrl=%h want run=0 ctrl=0", i, run, obs);
         end
      end
   endtask

   task automatic do_clear();
      @(negedge clock); #1;
      clear = 1'b0;
      #1;
      n_checks++;
      if (obs !== 33'd0 || step !== 3'd0 || run !== 1'b1) begin
         n_fail++;
         $display("FAIL clear_pulse: got ctrl=%h step=%0d run=%b want 0/0/1", obs, step, run);
      end
      @(negedge clock);
      clear = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_reset();
      logic h;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_checks++;
         if (obs !== 33'd0 || step !== 3'd0 || run !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold: got ctrl=%h step=%0d run=%b want 0/0/1", obs, step, run);
         end
      end
      clear = 1'b1;
      @(posedge clock); #1;
      run_instr(32'd0, 1'b0, 1'b0, -1, h);
   endtask

   task automatic test_add();
      logic h;
      run_instr({OP_ADD, 4'd1, 4'd2, 4'd3, 15'd0}, 1'b0, 1'b0, -1, h);
      run_instr({OP_ADDI, 4'd4, 4'd5, 19'h7}, 1'b0, 1'b0, -1, h);
   endtask

   task automatic test_ld();
      logic h;
      run_instr({OP_LD, 4'd1, 4'd2, 19'h10}, 1'b0, 1'b0, -1, h);
      run_instr({OP_ST, 4'd3, 4'd2, 19'h20}, 1'b0, 1'b0, -1, h);
   endtask

   task automatic test_branch();
      logic h;
      run_instr({OP_BR, 4'd2, 4'd0, 19'h8}, 1'b0, 1'b0, -1, h);
      run_instr({OP_BR, 4'd2, 4'd0, 19'h8}, 1'b1, 1'b0, -1, h);
   endtask

   task automatic test_stop();
      logic h;
      run_instr({OP_ADD, 4'd1, 4'd2, 4'd3, 15'd0}, 1'b0, 1'b1, -1, h);
      check_halted(10);
      do_clear();
      run_instr({OP_NOP, 27'd0}, 1'b0, 1'b0, -1, h);
   endtask

   task automatic test_halt_op();
      logic h;
      run_instr({OP_HALT, 27'd0}, 1'b0, 1'b0, -1, h);
      check_halted(4);
      do_clear();
   endtask

   task automatic test_clear_mid();
      logic h;
      run_instr({OP_LD, 4'd1, 4'd2, 19'h10}, 1'b0, 1'b0, 5, h);
      #1;
      clear = 1'b0;
      #1;
      n_checks++;
      if (obs !== 33'd0 || step !== 3'd0 || run !== 1'b1) begin
         n_fail++;
         $display("FAIL clear_mid: got ctrl=%h step=%0d run=%b want 0/0/1", obs, step, run);
      end
      @(posedge clock); #1;
      n_checks++;
      if (Read !== 1'b0 || Write !== 1'b0 || obs !== 33'd0) begin
         n_fail++;
         $display("FAIL clear_mid_hold: got rd=%b wr=%b ctrl=%h want all 0", Read, Write, obs);
      end
      @(negedge clock);
      clear = 1'b1;
      @(posedge clock); #1;
      run_instr({OP_NOP, 27'd0}, 1'b0, 1'b0, -1, h);
   endtask

   task automatic test_random();
      logic h;
      logic [31:0] instr;
      for (int n = 0; n < 60; n++) begin
         instr = $urandom;
         run_instr(instr, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), -1, h);
         if (h) begin
            check_halted(3);
            do_clear();
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_add();
      test_ld();
      test_branch();
      test_stop();
      test_halt_op();
      test_clear_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-002 SHALL have: clear  in  1  asynchronous active-low reset.
REQ-003 SHALL have: stop  in  1  halt request, sampled only at instruction end.
REQ-004 SHALL have: ir  in  32  IR register output; opcode = ir[31:27].
REQ-005 SHALL have: con  in  1  branch condition from CON FF.
REQ-006 SHALL have: bus-drive outs, each 1 bit: PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout, Cout.
REQ-007 SHALL have: load-enable outs, each 1 bit: PCin, IRin, MARin, MDRin, Yin, Zhighin, Zlowin, HIin, LOin, OutPortin, CONin, IncPC.
REQ-008 SHALL have: select outs, each 1 bit: Gra, Grb, Grc, Rin, Rout, BAout, Read, Write.
REQ-009 SHALL have: alu_op  out  5  ALU operation code.
REQ-010 SHALL have: run  out  1  high unless halted; step  out  3  current T-state.

Function
REQ-011 SHALL be a Moore FSM; all outputs are decoded from registered state (step, halted) plus ir and con only.
REQ-012 SHALL generate fetch as T0: PCout, MARin, IncPC, Zlowin; T1: Zlowout, PCin, Read, MDRin; T2: MDRout, IRin.
REQ-013 SHALL, for 3-register ALU ops (add, sub, and, or, shr, shl, ror, rol), generate T3: Grb, Rout, Yin; T4: Grc, Rout, alu_op=opcode, Zlowin; T5: Zlowout, Gra, Rin; then T0.
REQ-014 SHALL, for immediate ops (addi, andi, ori), generate T4 with Cout in place of Grc/Rout; otherwise as REQ-013.
REQ-015 SHALL, for ld/ldi/st, generate T3: Grb, BAout, Yin; T4: Cout, alu_op=ADD, Zlowin. ldi: T5 Zlowout, Gra, Rin. ld: T5 Zlowout, MARin; T6 Read, MDRin; T7 MDRout, Gra, Rin. st: T5 Zlowout, MARin; T6 Gra, Rout, Write.
REQ-016 SHALL, for branch, generate T3: Gra, Rout, CONin; T4: PCout, Yin; T5: Cout, alu_op=ADD, Zlowin; T6: Zlowout and PCin asserted only if con=1.
REQ-017 SHALL, for jr: T3 Gra, Rout, PCin; jal: T3 PCout, Grb, Rin (r15 link); T4 Gra, Rout, PCin.
REQ-018 SHALL, for in/out/mfhi/mflo: T3 one transfer (InPortout|Gra|Rin, Gra|Rout|OutPortin, HIout|Gra|Rin, LOout|Gra|Rin).
REQ-019 SHALL treat nop and undefined opcodes as ending after T2 (next state T0).
REQ-020 SHALL, on halt opcode, enter HALT after T2: run=0, all controls 0, held until clear asserted.
REQ-021 SHALL, on the final T-state of any instruction, enter HALT instead of T0 if stop=1 that cycle.
REQ-022 SHALL never assert Read and Write together, nor more than one bus-drive output per cycle.
REQ-023 SHALL drive alu_op=0 whenever Zlowin is not asserted.

Reset
REQ-024 SHALL, while clear=0, force step=T0, halted=0, all control outputs 0, run=1, independent of clock.
REQ-025 SHALL, after clear deasserts, begin fetch at T0 on the first rising clock edge; a reset mid-instruction abandons it with no partial write.

Configuration
REQ-026 SHALL, with CU_MULDIV_EN defined, sequence mul/div as T3 Gra,Rout,Yin; T4 Grb,Rout,alu_op,Zlowin,Zhighin; T5 Zlowout,LOin; T6 Zhighout,HIin.
REQ-027 SHALL, without CU_MULDIV_EN, treat mul/div opcodes as nop per REQ-019.

Structure
REQ-028 SHALL take opcode encodings, ALU op codes and T-state constants from shared package cpu_pkg.
REQ-029 SHALL contain one sub-module, cu_step_counter (3-bit counter with sync zero and hold), instantiated once.

Verification
REQ-030 SHALL cover: reset released, ir=0 -> T0 asserts PCout,MARin,IncPC,Zlowin; T2 asserts IRin; run=1.
REQ-031 SHALL cover: add r1,r2,r3 -> T4 alu_op=ADD with Zlowin; T5 Gra,Rin,Zlowout; next cycle step=0.
REQ-032 SHALL cover: ld r1,0x10(r2) -> T6 Read,MDRin; T7 MDRout,Rin; Write never high.
REQ-033 SHALL cover: branch with con=0 then con=1 -> PCin at T6 absent then present.
REQ-034 SHALL cover: stop=1 on last T-state of add -> run=0 next cycle, outputs 0 for 10 cycles; clear pulse restores T0.
REQ-035 SHALL cover: clear asserted at ld T5 -> outputs 0 immediately, no Read/Write, fetch restarts.
